ebi_write_decoder: RTL and testbench
====================================

# ebi_write_decoder

Upstream stage of `display_driver`. It captures MCU writes from the multiplexed EBI bus (`EBI_AD`/`EBI_ALE`/`EBI_WE`/`bank_select`) and turns them into single-cycle write strobes for the OAM, sprite, palette and TAM memories in the `clk_100m` domain. It synchronises the asynchronous strobes, pairs each latched address with its data, and routes the result by bank. OAM writes can optionally be held back until vertical blank.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `EBI_ALE` and `EBI_WE`; minimum 2.
- `FIFO_DEPTH`, 16: OAM defer FIFO entries; power of two. Only meaningful with the macro defined.

Ports:
- `clk_100m`  in  1  system clock, 100 MHz.
- `btn_rst`  in  1  reset; asynchronous, active-low.
- `EBI_AD`  in  16  multiplexed address/data from the MCU.
- `EBI_ALE`  in  1  address latch enable, active-low, asynchronous.
- `EBI_WE`  in  1  write enable, active-low, asynchronous.
- `bank_select`  in  3  target bank: 0 OAM, 1 SPRITE, 2 PALETTE, 3 TAM, 4–7 invalid.
- `vblank`  in  1  high during vertical blank, `clk_100m` domain.
- `err_clr`  in  1  one-cycle pulse; clears all sticky error flags.
- `wr_en`  out  1  one-cycle memory write strobe.
- `wr_sel`  out  4  one-hot bank select; valid while `wr_en` is high, 0 otherwise.
- `wr_addr`  out  16  write address.
- `wr_data`  out  16  write data.
- `err_bank`  out  1  sticky: a write targeted bank 4–7.
- `err_proto`  out  1  sticky: a WE strobe arrived with no address latched.
- `err_ovf`  out  1  sticky: an OAM write was dropped because the FIFO was full.

## Operation
- **Input capture.** `EBI_ALE`, `EBI_WE` pass through `SYNC_STAGES` flip-flops plus one history flip-flop. `EBI_AD` and `bank_select` are registered every cycle, delayed to match the strobe path.
- **Edge detection.** Only the deassert edges (0→1) of the synchronised ALE and WE are acted on.
- **FSM states:**
  - IDLE → ADDR on an ALE rise: latch `EBI_AD` as the address and latch `bank_select`.
  - ADDR → COMMIT on a WE rise: latch `EBI_AD` as the data.
  - ADDR → ADDR on a further ALE rise: the address is overwritten by the new one.
  - COMMIT → IDLE, unconditionally, after one cycle.
- **Protocol error.** A WE rise in IDLE sets `err_proto` and no write occurs.
- **COMMIT, bank 0–3.** Issue the write: `wr_en=1`, `wr_sel=1<<bank`, `wr_addr`/`wr_data` = the latched values.
- **COMMIT, bank 4–7.** No write; set `err_bank`.
- **ALE and WE rise in the same cycle.** The WE edge is processed first, using the old address. The ALE edge is then taken and the FSM lands in ADDR.
- **Error flags.** `err_clr` clears all sticky flags. If a set event and `err_clr` occur in the same cycle, the set wins.
- **Outputs between writes.** `wr_addr`/`wr_data` hold their last values.

## Timing
- **Reset.** Every output is 0 and the FSM is in IDLE. The synchronisers reset to 1, the strobe idle level. The FIFO is emptied.
- **Latency.** With `SYNC_STAGES`=2, `wr_en` rises at the 4th `clk_100m` rising edge after the first edge that samples `EBI_WE`=1. `wr_en` is high for exactly one cycle.
- **MCU timing requirement:**
  - ALE and WE low pulses of at least 3 clock cycles.
  - `EBI_AD`/`bank_select` stable from 3 cycles before to 1 cycle after each strobe rise.
  - At least 4 cycles between successive WE rises.
- **Reset mid-transaction.** Partial address or data is discarded. A WE rise after reset with no new ALE raises `err_proto`.

## Configuration
Macro: `OAM_VBLANK_DEFER_EN`.
- **Defined.**
  - Bank-0 commits do not write directly. Each `{addr,data}` is pushed into a FIFO of `FIFO_DEPTH` entries.
  - While `vblank`=1 the FIFO pops one entry per cycle as a write with `wr_sel`=4'b0001.
  - If a direct (bank 1–3) commit and a pop fall in the same cycle, the direct write wins and the pop stalls one cycle.
  - A push when the FIFO is full drops the entry and sets `err_ovf`.
  - A push and a pop in the same cycle are both allowed, including when the FIFO is full.
  - Entries drain in order; `vblank` falling stops the drain with the remaining entries kept.
- **Undefined.** Bank-0 writes go out directly like banks 1–3. There is no FIFO logic and `err_ovf` is tied to 0.

## Test plan
- **Basic write.** Reset, then ALE with AD=0x0012 and bank=2, then WE with AD=0xBEEF. Expect one `wr_en` pulse with `wr_sel`=4'b0100, addr 0x0012, data 0xBEEF, 4 cycles after the WE rise.
- **Strobe without address.** WE strobe with no prior ALE: expect no `wr_en` and `err_proto`=1. Then pulse `err_clr`: `err_proto`=0.
- **Invalid bank.** Bank=5 write: expect no `wr_en` and `err_bank`=1. A following valid bank-3 write produces `wr_sel`=4'b1000.
- **Address overwrite and reset abort.** Two ALEs (0x0001, then 0x0002) followed by one WE: the write goes to addr 0x0002. Assert `btn_rst` low between ALE and WE: no write, and the WE after reset sets `err_proto`.
- **OAM defer drain (macro defined).** 3 OAM writes with `vblank`=0: no `wr_en`. Raise `vblank`: 3 consecutive `wr_en` cycles, `wr_sel`=4'b0001, in original order.
- **OAM overflow and priority (macro defined, `FIFO_DEPTH`=16).** 17 OAM writes with `vblank`=0: `err_ovf`=1, and the drain yields exactly the first 16. A palette write landing during the drain takes its cycle and the drain resumes on the next cycle.

Source files
------------

// File: rtl/ebi_write_decoder.sv
// rtl/ebi_write_decoder.sv - EBI write capture: strobe sync, addr/data pairing, bank routing.
// Optional OAM_VBLANK_DEFER_EN holds OAM writes in a FIFO until vertical blank.
module ebi_write_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk_100m,
  input  logic        btn_rst,
  input  logic [15:0] EBI_AD,
  input  logic        EBI_ALE,
  input  logic        EBI_WE,
  input  logic [2:0]  bank_select,
  input  logic        vblank,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [3:0]  wr_sel,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        err_bank,
  output logic        err_proto,
  output logic        err_ovf
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_COMMIT} state_t;

  logic [SYNC_STAGES-1:0] ale_sync_q, we_sync_q;
  logic                   ale_hist_q, we_hist_q;
  logic [15:0]            ad_pipe_q   [SYNC_STAGES];
  logic [2:0]             bank_pipe_q [SYNC_STAGES];

  // Strobes idle high, so synchronisers and history reset to 1 to avoid a false rise.
  always_ff @(posedge clk_100m or negedge btn_rst) begin
    if (!btn_rst) begin
      ale_sync_q <= '1;
      we_sync_q  <= '1;
      ale_hist_q <= 1'b1;
      we_hist_q  <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ad_pipe_q[i]   <= '0;
        bank_pipe_q[i] <= '0;
      end
    end else begin
      ale_sync_q     <= {ale_sync_q[SYNC_STAGES-2:0], EBI_ALE};
      we_sync_q      <= {we_sync_q[SYNC_STAGES-2:0], EBI_WE};
      ale_hist_q     <= ale_sync_q[SYNC_STAGES-1];
      we_hist_q      <= we_sync_q[SYNC_STAGES-1];
      ad_pipe_q[0]   <= EBI_AD;
      bank_pipe_q[0] <= bank_select;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ad_pipe_q[i]   <= ad_pipe_q[i-1];
        bank_pipe_q[i] <= bank_pipe_q[i-1];
      end
    end
  end

  logic        ale_rise, we_rise;
  logic [15:0] ad_s;
  logic [2:0]  bank_s;
  assign ale_rise = ale_sync_q[SYNC_STAGES-1] & ~ale_hist_q;
  assign we_rise  = we_sync_q[SYNC_STAGES-1] & ~we_hist_q;
  assign ad_s     = ad_pipe_q[SYNC_STAGES-1];
  assign bank_s   = bank_pipe_q[SYNC_STAGES-1];

  state_t      state_q;
  logic [15:0] addr_q, cm_addr_q, cm_data_q;
  logic [2:0]  bank_q, cm_bank_q;
  logic        pend_q;
  logic        wr_en_q, err_bank_q, err_proto_q;
  logic [3:0]  wr_sel_q;
  logic [15:0] wr_addr_q, wr_data_q;
  logic        direct_wr;

`ifdef OAM_VBLANK_DEFER_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, push, push_ok, pop, err_ovf_q;
  logic [31:0]   fifo_head;

  assign direct_wr = pend_q & ~cm_bank_q[2] & (cm_bank_q[1:0] != 2'b00);
  assign push      = pend_q & (cm_bank_q == 3'd0);
  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = vblank & (count_q != '0) & ~direct_wr;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign push_ok   = push & (~fifo_full | pop);
  assign fifo_head = fifo_mem[rd_ptr_q];
  assign err_ovf   = err_ovf_q;

  always_ff @(posedge clk_100m) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {cm_addr_q, cm_data_q};
  end

  always_ff @(posedge clk_100m or negedge btn_rst) begin
    if (!btn_rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      err_ovf_q <= (push & fifo_full & ~pop) | (err_ovf_q & ~err_clr);
    end
  end
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign direct_wr     = pend_q & ~cm_bank_q[2];
  assign err_ovf       = 1'b0;
`endif

  always_ff @(posedge clk_100m or negedge btn_rst) begin
    if (!btn_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bank_q      <= '0;
      cm_addr_q   <= '0;
      cm_data_q   <= '0;
      cm_bank_q   <= '0;
      pend_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_bank_q  <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      // WE is handled before ALE so a simultaneous pair commits the old address.
      if (we_rise && state_q == S_ADDR) begin
        cm_addr_q <= addr_q;
        cm_bank_q <= bank_q;
        cm_data_q <= ad_s;
        pend_q    <= 1'b1;
        state_q   <= S_COMMIT;
      end
      if (state_q == S_COMMIT) state_q <= S_IDLE;
      if (ale_rise && state_q != S_COMMIT) begin
        addr_q  <= ad_s;
        bank_q  <= bank_s;
        state_q <= S_ADDR;
      end

      wr_en_q  <= 1'b0;
      wr_sel_q <= '0;
      if (direct_wr) begin
        wr_en_q   <= 1'b1;
        wr_sel_q  <= 4'b0001 << cm_bank_q[1:0];
        wr_addr_q <= cm_addr_q;
        wr_data_q <= cm_data_q;
      end
`ifdef OAM_VBLANK_DEFER_EN
      else if (pop) begin
        wr_en_q                <= 1'b1;
        wr_sel_q               <= 4'b0001;
        {wr_addr_q, wr_data_q} <= fifo_head;
      end
`endif
      err_bank_q  <= (pend_q & cm_bank_q[2]) | (err_bank_q & ~err_clr);
      err_proto_q <= (we_rise & (state_q == S_IDLE)) | (err_proto_q & ~err_clr);
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err_bank  = err_bank_q;
  assign err_proto = err_proto_q;

endmodule

// File: tb/tb_ebi_write_decoder.sv
// tb/tb_ebi_write_decoder.sv - directed and randomized bench for ebi_write_decoder.
module tb_ebi_write_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ad;
  logic        ale, we;
  logic [2:0]  bank;
  logic        vblank, err_clr;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_addr, wr_data;
  logic        err_bank, err_proto, err_ovf;

  ebi_write_decoder dut (
    .clk_100m(clk), .btn_rst(rst_n), .EBI_AD(ad), .EBI_ALE(ale), .EBI_WE(we),
    .bank_select(bank), .vblank(vblank), .err_clr(err_clr),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_bank(err_bank), .err_proto(err_proto), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_cyc;
  int sel_leak = 0;

  logic [15:0] cap_addr[$];
  logic [15:0] cap_data[$];
  logic [3:0]  cap_sel[$];
  int          cap_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_sel.push_back(wr_sel);
      cap_cyc.push_back(cyc);
    end else if (wr_sel != 4'b0000) begin
      sel_leak++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    cap_addr.delete();
    cap_data.delete();
    cap_sel.delete();
    cap_cyc.delete();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    settle(1);
    err_clr = 1'b0;
    settle(1);
  endtask

  task automatic ale_strobe(input logic [15:0] a, input logic [2:0] b);
    ad = a;
    bank = b;
    settle(3);
    ale = 1'b0;
    settle(3);
    ale = 1'b1;
    settle(2);
  endtask

  task automatic we_strobe(input logic [15:0] d);
    ad = d;
    settle(3);
    we = 1'b0;
    settle(3);
    we = 1'b1;
    we_cyc = cyc;
    settle(2);
  endtask

  task automatic both_strobe(input logic [15:0] v, input logic [2:0] b);
    ad = v;
    bank = b;
    settle(3);
    ale = 1'b0;
    we  = 1'b0;
    settle(3);
    ale = 1'b1;
    we  = 1'b1;
    settle(2);
  endtask

  // Expect exactly one write with the given fields among the captured ones.
  task automatic expect_one(input string tag, input logic [15:0] a, input logic [15:0] d,
                            input logic [3:0] s);
    chk({tag, "_count"}, cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      chk({tag, "_addr"}, cap_addr[0], a);
      chk({tag, "_data"}, cap_data[0], d);
      chk({tag, "_sel"},  cap_sel[0],  s);
    end
    flush();
  endtask

  initial begin
    logic        has_addr;
    logic [15:0] m_addr, m_data;
    logic [2:0]  m_bank;
    int          op, n_ale;

    rst_n = 1'b0; ad = '0; ale = 1'b1; we = 1'b1; bank = '0; vblank = 1'b0; err_clr = 1'b0;
    settle(3);
    chk("rst_outputs", {wr_en, wr_sel, err_bank, err_proto, err_ovf}, 0);
    chk("rst_addr_data", {wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    settle(3);
    flush();

    // basic write and latency
    ale_strobe(16'h0012, 3'd2);
    we_strobe(16'hBEEF);
    settle(8);
    if (cap_cyc.size() == 1) chk("latency", cap_cyc[0] - we_cyc, 4);
    else chk("latency_count", cap_cyc.size(), 1);
    expect_one("basic", 16'h0012, 16'hBEEF, 4'b0100);
    chk("hold_addr", wr_addr, 16'h0012);

    // strobe without address
    we_strobe(16'h1111);
    settle(8);
    chk("proto_nowrite", cap_addr.size(), 0);
    chk("proto_set", err_proto, 1'b1);
    clear_err();
    chk("proto_clr", err_proto, 1'b0);
    flush();

    // invalid bank, then valid bank 3
    ale_strobe(16'h0040, 3'd5);
    we_strobe(16'h2222);
    settle(8);
    chk("bank_nowrite", cap_addr.size(), 0);
    chk("bank_set", err_bank, 1'b1);
    clear_err();
    chk("bank_clr", err_bank, 1'b0);
    flush();
    ale_strobe(16'h0041, 3'd3);
    we_strobe(16'h3333);
    settle(8);
    expect_one("bank3", 16'h0041, 16'h3333, 4'b1000);

    // address overwrite
    ale_strobe(16'h0001, 3'd1);
    ale_strobe(16'h0002, 3'd1);
    we_strobe(16'h55AA);
    settle(8);
    expect_one("overwrite", 16'h0002, 16'h55AA, 4'b0010);

    // simultaneous ALE and WE: old address commits, new one stays latched
    ale_strobe(16'h0010, 3'd1);
    both_strobe(16'h0020, 3'd2);
    settle(8);
    expect_one("same_cyc1", 16'h0010, 16'h0020, 4'b0010);
    chk("same_cyc_noerr", {err_proto, err_bank}, 0);
    we_strobe(16'h0030);
    settle(8);
    expect_one("same_cyc2", 16'h0020, 16'h0030, 4'b0100);

    // reset between ALE and WE
    ale_strobe(16'h0077, 3'd3);
    rst_n = 1'b0;
    settle(2);
    rst_n = 1'b1;
    settle(2);
    we_strobe(16'h1234);
    settle(8);
    chk("rst_abort_nowrite", cap_addr.size(), 0);
    chk("rst_abort_proto", err_proto, 1'b1);
    clear_err();
    flush();

`ifdef OAM_VBLANK_DEFER_EN
    // deferred OAM drain
    for (int i = 0; i < 3; i++) begin
      ale_strobe(16'h0100 + 16'(i), 3'd0);
      we_strobe(16'hD000 + 16'(i));
    end
    settle(8);
    chk("defer_hold", cap_addr.size(), 0);
    vblank = 1'b1;
    settle(8);
    vblank = 1'b0;
    chk("defer_count", cap_addr.size(), 3);
    for (int i = 0; i < cap_addr.size() && i < 3; i++) begin
      chk("defer_addr", cap_addr[i], 16'h0100 + 16'(i));
      chk("defer_data", cap_data[i], 16'hD000 + 16'(i));
      chk("defer_sel", cap_sel[i], 4'b0001);
      chk("defer_consec", cap_cyc[i] - cap_cyc[0], i);
    end
    flush();

    // overflow, then a palette write landing inside the drain
    for (int i = 0; i < 17; i++) begin
      ale_strobe(16'h0200 + 16'(i), 3'd0);
      we_strobe(16'hA000 + 16'(i));
    end
    settle(8);
    chk("ovf_set", err_ovf, 1'b1);
    chk("ovf_hold", cap_addr.size(), 0);
    ale_strobe(16'h0300, 3'd2);
    ad = 16'hC0DE;
    settle(3);
    we = 1'b0;
    settle(3);
    we = 1'b1;
    vblank = 1'b1;
    settle(30);
    vblank = 1'b0;
    chk("drain_count", cap_addr.size(), 17);
    begin
      int oi = 0;
      int pal = 0;
      for (int i = 0; i < cap_addr.size(); i++) begin
        chk("drain_consec", cap_cyc[i] - cap_cyc[0], i);
        if (cap_sel[i] == 4'b0100) begin
          pal++;
          chk("pal_addr", cap_addr[i], 16'h0300);
          chk("pal_data", cap_data[i], 16'hC0DE);
        end else begin
          chk("drain_sel", cap_sel[i], 4'b0001);
          chk("drain_addr", cap_addr[i], 16'h0200 + 16'(oi));
          chk("drain_data", cap_data[i], 16'hA000 + 16'(oi));
          oi++;
        end
      end
      chk("drain_oam_n", oi, 16);
      chk("drain_pal_n", pal, 1);
    end
    clear_err();
    chk("ovf_clr", err_ovf, 1'b0);
    flush();
`else
    chk("ovf_tied", err_ovf, 1'b0);
`endif

    // randomized transactions against the protocol model
    vblank = 1'b1;
    has_addr = 1'b0;
    m_addr = '0;
    m_bank = '0;
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 9);
      if (op != 0) begin
        n_ale = (op == 1) ? 2 : 1;
        for (int k = 0; k < n_ale; k++) begin
          m_addr = 16'($urandom);
          m_bank = 3'($urandom_range(0, 7));
          ale_strobe(m_addr, m_bank);
          has_addr = 1'b1;
        end
      end
      m_data = 16'($urandom);
      we_strobe(m_data);
      settle(8);
      if (has_addr && m_bank < 3'd4) begin
        expect_one("rnd", m_addr, m_data, 4'(1 << m_bank));
        chk("rnd_noerr", {err_bank, err_proto}, 0);
      end else if (has_addr) begin
        chk("rnd_badbank_nowrite", cap_addr.size(), 0);
        chk("rnd_badbank_flag", {err_bank, err_proto}, 2'b10);
      end else begin
        chk("rnd_proto_nowrite", cap_addr.size(), 0);
        chk("rnd_proto_flag", {err_bank, err_proto}, 2'b01);
      end
      has_addr = 1'b0;
      flush();
      clear_err();
    end

    chk("sel_zero_when_idle", sel_leak, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
